// File: rtl/agc_pwr_est_if.sv
// Sample/result bundle for agc_pwr_est; sat_cnt exists only when
// AGC_PWR_EST_SAT_CNT_EN is defined.
interface agc_pwr_est_if #(parameter int DW = 10);
    logic                 est_ena;
    logic                 iq_valid;
    logic signed [DW-1:0] i_data;
    logic signed [DW-1:0] q_data;
    logic [1:0]           win_sel;
    logic [8:0]           pwr_est_dB;
    logic                 pwr_est_end;
    logic                 est_busy;
`ifdef AGC_PWR_EST_SAT_CNT_EN
    logic [11:0]          sat_cnt;

    modport master (output est_ena, iq_valid, i_data, q_data, win_sel,
                    input  pwr_est_dB, pwr_est_end, est_busy, sat_cnt);
    modport slave  (input  est_ena, iq_valid, i_data, q_data, win_sel,
                    output pwr_est_dB, pwr_est_end, est_busy, sat_cnt);
`else
    modport master (output est_ena, iq_valid, i_data, q_data, win_sel,
                    input  pwr_est_dB, pwr_est_end, est_busy);
    modport slave  (input  est_ena, iq_valid, i_data, q_data, win_sel,
                    output pwr_est_dB, pwr_est_end, est_busy);
`endif
endinterface

// File: rtl/agc_pwr_est.sv
// Windowed I^2+Q^2 power estimator with 0.125 dB/LSB log output.
// Optional saturated-sample counter enabled by AGC_PWR_EST_SAT_CNT_EN.
module agc_pwr_est #(
    parameter int DW = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    agc_pwr_est_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACC, LOG1, LOG2, LOG3} state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [11:0] cnt_q, cnt_d;
    logic [1:0]  win_q, win_d;
    logic [19:0] mean_q, mean_d;
    logic [8:0]  log2q_q, log2q_d;
    logic [8:0]  db_q, db_d;
    logic        end_q, end_d;

    logic signed [2*DW-1:0] i_sq, q_sq;
    logic [2*DW-1:0]        pwr;
    logic [11:0]            last_idx;
    logic                   take;
    logic [4:0]             shamt;
    logic [31:0]            acc_shr;
    logic [4:0]             lead;
    logic [19:0]            norm;
    logic [17:0]            db_prod;
    logic [9:0]             db_raw;

    assign i_sq    = bus.i_data * bus.i_data;
    assign q_sq    = bus.q_data * bus.q_data;
    assign pwr     = $unsigned(i_sq) + $unsigned(q_sq);
    // The pulse cycle is dead time: the new window starts one cycle later.
    assign take    = bus.iq_valid && !end_q;
    assign shamt   = 5'd6 + {2'b00, win_q, 1'b0};
    assign acc_shr = acc_q >> shamt;
    assign norm    = mean_q << (5'd19 - lead);
    assign db_prod = 18'(log2q_q) * 18'd385;
    assign db_raw  = db_prod[17:8];

    always_comb begin
        case (win_q)
            2'd0:    last_idx = 12'd63;
            2'd1:    last_idx = 12'd255;
            2'd2:    last_idx = 12'd1023;
            default: last_idx = 12'd4095;
        endcase
    end

    always_comb begin
        lead = '0;
        for (int unsigned b = 0; b < 20; b++) begin
            if (mean_q[b]) lead = 5'(b);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        mean_d  = mean_q;
        log2q_d = log2q_q;
        db_d    = db_q;
        end_d   = 1'b0;
        if (!bus.est_ena) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACC;
                    win_d   = bus.win_sel;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
                ACC: begin
                    if (take) begin
                        acc_d = acc_q + 32'(pwr);
                        cnt_d = cnt_q + 12'd1;
                        if (cnt_q == last_idx) state_d = LOG1;
                    end
                end
                LOG1: begin
                    mean_d  = acc_shr[19:0];
                    state_d = LOG2;
                end
                LOG2: begin
                    log2q_d = (mean_q == '0) ? '0 : {lead, norm[18:15]};
                    state_d = LOG3;
                end
                LOG3: begin
                    db_d    = (db_raw > 10'd511) ? 9'd511 : db_raw[8:0];
                    end_d   = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    win_d   = bus.win_sel;
                    state_d = ACC;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            mean_q  <= '0;
            log2q_q <= '0;
            db_q    <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            mean_q  <= mean_d;
            log2q_q <= log2q_d;
            db_q    <= db_d;
            end_q   <= end_d;
        end
    end

    assign bus.pwr_est_dB  = db_q;
    assign bus.pwr_est_end = end_q;
    assign bus.est_busy    = (state_q != IDLE);

`ifdef AGC_PWR_EST_SAT_CNT_EN
    localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    logic [11:0] satc_q, satc_d, sato_q, sato_d;
    logic        is_sat;

    assign is_sat = (bus.i_data == SMAX) || (bus.i_data == SMIN) ||
                    (bus.q_data == SMAX) || (bus.q_data == SMIN);

    always_comb begin
        satc_d = satc_q;
        sato_d = sato_q;
        if (!bus.est_ena || state_q == IDLE || state_q == LOG3) begin
            satc_d = '0;
        end else if (state_q == ACC && take && is_sat) begin
            satc_d = satc_q + 12'd1;
        end
        if (bus.est_ena && state_q == LOG3) sato_d = satc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            satc_q <= '0;
            sato_q <= '0;
        end else begin
            satc_q <= satc_d;
            sato_q <= sato_d;
        end
    end

    assign bus.sat_cnt = sato_q;
`endif
endmodule
